// File: rtl/flp32_dot_seq_if.sv
// Bundle of the upstream operand stream, MAC issue/return and result ports of flp32_dot_seq.
// slave is the sequencer's view; master is the surrounding environment's view.
interface flp32_dot_seq_if #(
  parameter int CNT_W = 16
);
  logic             i_start;
  logic [CNT_W-1:0] i_len;
  logic [31:0]      i_a;
  logic [31:0]      i_b;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      o_mac_a;
  logic [31:0]      o_mac_b;
  logic [31:0]      o_mac_c;
  logic             o_mac_valid;
  logic [31:0]      i_mac_p;
  logic             i_mac_nan;
  logic             i_mac_inf;
  logic             i_mac_valid;
  logic [31:0]      o_res;
  logic             o_res_nan;
  logic             o_res_inf;
  logic             o_res_err;
  logic             o_res_valid;
  logic             o_busy;

  modport slave (
    input  i_start, i_len, i_a, i_b, i_valid, i_mac_p, i_mac_nan, i_mac_inf, i_mac_valid,
    output o_ready, o_mac_a, o_mac_b, o_mac_c, o_mac_valid,
    output o_res, o_res_nan, o_res_inf, o_res_err, o_res_valid, o_busy
  );

  modport master (
    output i_start, i_len, i_a, i_b, i_valid, i_mac_p, i_mac_nan, i_mac_inf, i_mac_valid,
    input  o_ready, o_mac_a, o_mac_b, o_mac_c, o_mac_valid,
    input  o_res, o_res_nan, o_res_inf, o_res_err, o_res_valid, o_busy
  );
endinterface

// File: rtl/flp32_dot_seq.sv
// Dot-product sequencer in front of a pipelined FP32 MAC: one pair in flight at a time.
// Optional MAC-return watchdog enabled by defining FLP_DOTSEQ_WDOG_EN.
module flp32_dot_seq #(
  parameter int CNT_W   = 16,
  parameter int MAC_LAT = 5
) (
  input  logic           clk,
  input  logic           rst,
  flp32_dot_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc;
  logic             nan_s, inf_s;
  logic [31:0]      mac_a, mac_b, mac_c;
  logic             mac_valid;
  logic [31:0]      res;
  logic             res_nan, res_inf;
  logic             start_take, take, mac_take, timeout;

  assign start_take = (state == IDLE)  && bus.i_start;
  assign take       = (state == ISSUE) && bus.i_valid;
  assign mac_take   = (state == WAIT)  && bus.i_mac_valid;

`ifdef FLP_DOTSEQ_WDOG_EN
  localparam int WD_W = $clog2(MAC_LAT + 2) + 1;
  logic [WD_W-1:0] wd;
  logic            err;

  // wd counts WAIT cycles from 0; the last accepted return slot is wd == MAC_LAT+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wd <= '0;
    else if (state != WAIT)  wd <= '0;
    else                     wd <= wd + WD_W'(1);
  end

  assign timeout = (state == WAIT) && !bus.i_mac_valid && (wd == WD_W'(MAC_LAT + 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err <= 1'b0;
    else if (start_take) err <= 1'b0;
    else if (timeout)    err <= 1'b1;
  end

  assign bus.o_res_err = err;
`else
  assign timeout       = 1'b0;
  assign bus.o_res_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.i_start) state_nx = (bus.i_len != '0) ? ISSUE : DONE;
      ISSUE:   if (bus.i_valid) state_nx = WAIT;
      WAIT: begin
        if (bus.i_mac_valid) state_nx = (cnt == '0) ? DONE : ISSUE;
        else if (timeout)    state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result registers load on the transition into DONE so they are valid during DONE and hold after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      nan_s     <= 1'b0;
      inf_s     <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_c     <= '0;
      mac_valid <= 1'b0;
      res       <= '0;
      res_nan   <= 1'b0;
      res_inf   <= 1'b0;
    end else begin
      mac_valid <= 1'b0;
      if (start_take) begin
        cnt   <= bus.i_len;
        acc   <= '0;
        nan_s <= 1'b0;
        inf_s <= 1'b0;
        if (bus.i_len == '0) begin
          res     <= '0;
          res_nan <= 1'b0;
          res_inf <= 1'b0;
        end
      end
      if (take) begin
        mac_a     <= bus.i_a;
        mac_b     <= bus.i_b;
        mac_c     <= acc;
        mac_valid <= 1'b1;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
      if (mac_take) begin
        acc   <= bus.i_mac_p;
        nan_s <= nan_s | bus.i_mac_nan;
        inf_s <= inf_s | bus.i_mac_inf;
        if (cnt == '0) begin
          res     <= bus.i_mac_p;
          res_nan <= nan_s | bus.i_mac_nan;
          res_inf <= inf_s | bus.i_mac_inf;
        end
      end
      if (timeout) begin
        res     <= acc;
        res_nan <= nan_s;
        res_inf <= inf_s;
      end
    end
  end

  assign bus.o_ready     = (state == ISSUE);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_res_valid = (state == DONE);
  assign bus.o_mac_a     = mac_a;
  assign bus.o_mac_b     = mac_b;
  assign bus.o_mac_c     = mac_c;
  assign bus.o_mac_valid = mac_valid;
  assign bus.o_res       = res;
  assign bus.o_res_nan   = res_nan;
  assign bus.o_res_inf   = res_inf;

endmodule

// File: tb/tb_flp32_dot_seq.sv
// Directed bench for flp32_dot_seq with an ideal fixed-latency MAC stub returning hand-computed results.
module tb_flp32_dot_seq;
  localparam int CNT_W   = 16;
  localparam int MAC_LAT = 5;
  localparam int NV      = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flp32_dot_seq_if #(.CNT_W(CNT_W)) bus ();

  flp32_dot_seq #(.CNT_W(CNT_W), .MAC_LAT(MAC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [31:0] p;
    logic        n;
    logic        i;
  } mres_t;

  typedef struct packed {
    logic [15:0]      len;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0][31:0] c;
    logic [3:0][31:0] p;
    logic [3:0]       pn;
    logic [3:0]       pi;
    logic [31:0]      res;
    logic             nan;
    logic             inf;
  } vec_t;

  mres_t       mac_q[$];
  bit          mac_en = 1'b1;
  int unsigned issues = 0;
  int unsigned cycle  = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          hv [MAC_LAT];
  mres_t       hr [MAC_LAT];

  always @(posedge clk) cycle++;

  // Ideal MAC: returns the queued result MAC_LAT cycles after each issue pulse
  always @(negedge clk) begin
    bus.i_mac_valid = hv[MAC_LAT-1] & mac_en;
    bus.i_mac_p     = hr[MAC_LAT-1].p;
    bus.i_mac_nan   = hr[MAC_LAT-1].n;
    bus.i_mac_inf   = hr[MAC_LAT-1].i;
    for (int k = MAC_LAT - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hr[k] = hr[k-1];
    end
    hv[0] = (bus.o_mac_valid === 1'b1);
    hr[0] = '0;
    if (bus.o_mac_valid === 1'b1) begin
      issues++;
      if (mac_q.size() > 0) hr[0] = mac_q.pop_front();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] len);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len   = len;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic issue_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_c, output int unsigned hs);
    int unsigned n;
    n = 0;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_valid = 1'b1;
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, 32'(bus.o_ready), 32'd1);
    hs = cycle;
    @(negedge clk);
    check({tag, " mac_valid"}, 32'(bus.o_mac_valid), 32'd1);
    check({tag, " mac_a"}, bus.o_mac_a, a);
    check({tag, " mac_b"}, bus.o_mac_b, b);
    check({tag, " mac_c"}, bus.o_mac_c, exp_c);
    check({tag, " ready in wait"}, 32'(bus.o_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int unsigned hs, input logic [31:0] exp_res,
                           input logic exp_nan, input logic exp_inf, input logic exp_err,
                           input int unsigned exp_lat);
    int unsigned n;
    n = 0;
    while (!bus.o_res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " res_valid"}, 32'(bus.o_res_valid), 32'd1);
    check({tag, " latency"}, cycle - hs, exp_lat);
    check({tag, " res"}, bus.o_res, exp_res);
    check({tag, " res_nan"}, 32'(bus.o_res_nan), 32'(exp_nan));
    check({tag, " res_inf"}, 32'(bus.o_res_inf), 32'(exp_inf));
    check({tag, " res_err"}, 32'(bus.o_res_err), 32'(exp_err));
    @(negedge clk);
    check({tag, " res_valid drop"}, 32'(bus.o_res_valid), 32'd0);
    check({tag, " busy after"}, 32'(bus.o_busy), 32'd0);
    check({tag, " res hold"}, bus.o_res, exp_res);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: cycle %0d exceeds limit", cycle);
    $fatal(1);
  end

  initial begin
    vec_t        vecs [NV];
    int unsigned hs, prev, base;
    string       tag;

    for (int v = 0; v < NV; v++) vecs[v] = '0;
    // 1*2
    vecs[0].len = 1;
    vecs[0].a[0] = 32'h3f800000; vecs[0].b[0] = 32'h40000000; vecs[0].c[0] = 32'h0;
    vecs[0].p[0] = 32'h40000000; vecs[0].res = 32'h40000000;
    // 1*2 + 3*4 + 0.5*4 = 16
    vecs[1].len = 3;
    vecs[1].a[0] = 32'h3f800000; vecs[1].b[0] = 32'h40000000; vecs[1].c[0] = 32'h0;
    vecs[1].p[0] = 32'h40000000;
    vecs[1].a[1] = 32'h40400000; vecs[1].b[1] = 32'h40800000; vecs[1].c[1] = 32'h40000000;
    vecs[1].p[1] = 32'h41600000;
    vecs[1].a[2] = 32'h3f000000; vecs[1].b[2] = 32'h40800000; vecs[1].c[2] = 32'h41600000;
    vecs[1].p[2] = 32'h41800000; vecs[1].res = 32'h41800000;
    // +inf then (-1*inf) + inf = NaN: both sticky flags end up set
    vecs[2].len = 2;
    vecs[2].a[0] = 32'h7f800000; vecs[2].b[0] = 32'h3f800000; vecs[2].c[0] = 32'h0;
    vecs[2].p[0] = 32'h7f800000; vecs[2].pi[0] = 1'b1;
    vecs[2].a[1] = 32'hbf800000; vecs[2].b[1] = 32'h7f800000; vecs[2].c[1] = 32'h7f800000;
    vecs[2].p[1] = 32'h7fc00000; vecs[2].pn[1] = 1'b1;
    vecs[2].res = 32'h7fc00000; vecs[2].nan = 1'b1; vecs[2].inf = 1'b1;
    // qNaN operand propagates
    vecs[3].len = 2;
    vecs[3].a[0] = 32'h7fc00000; vecs[3].b[0] = 32'h3f800000; vecs[3].c[0] = 32'h0;
    vecs[3].p[0] = 32'h7fc00000; vecs[3].pn[0] = 1'b1;
    vecs[3].a[1] = 32'h3f800000; vecs[3].b[1] = 32'h40000000; vecs[3].c[1] = 32'h7fc00000;
    vecs[3].p[1] = 32'h7fc00000; vecs[3].pn[1] = 1'b1;
    vecs[3].res = 32'h7fc00000; vecs[3].nan = 1'b1;
    // zero length
    vecs[4].len = 0;

    bus.i_start = 1'b0;
    bus.i_len   = '0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.o_busy), 32'd0);
    check("reset ready", 32'(bus.o_ready), 32'd0);
    check("reset mac_valid", 32'(bus.o_mac_valid), 32'd0);
    check("reset res_valid", 32'(bus.o_res_valid), 32'd0);
    check("reset res", bus.o_res, 32'h0);
    check("reset mac_c", bus.o_mac_c, 32'h0);
    check("reset res_err", 32'(bus.o_res_err), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      tag = $sformatf("vec%0d", v);
      for (int k = 0; k < int'(vecs[v].len); k++)
        mac_q.push_back({vecs[v].p[k], vecs[v].pn[k], vecs[v].pi[k]});
      base = issues;
      start_run(vecs[v].len);
      if (vecs[v].len == 0) begin
        check({tag, " zl res_valid"}, 32'(bus.o_res_valid), 32'd1);
        check({tag, " zl res"}, bus.o_res, 32'h0);
        check({tag, " zl res_nan"}, 32'(bus.o_res_nan), 32'd0);
        check({tag, " zl res_inf"}, 32'(bus.o_res_inf), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, " zl idle"}, 32'(bus.o_busy), 32'd0);
      end else begin
        check({tag, " busy"}, 32'(bus.o_busy), 32'd1);
        prev = 0;
        for (int k = 0; k < int'(vecs[v].len); k++) begin
          issue_pair($sformatf("%s pair%0d", tag, k), vecs[v].a[k], vecs[v].b[k], vecs[v].c[k], hs);
          if (k > 0) check({tag, " pair spacing"}, hs - prev, 32'd7);
          prev = hs;
        end
        bus.i_valid = 1'b0;
        wait_done(tag, hs, vecs[v].res, vecs[v].nan, vecs[v].inf, 1'b0, 7);
      end
      check({tag, " issue count"}, issues - base, 32'(vecs[v].len));
    end

    // Upstream stalls for 10 cycles in ISSUE
    mac_q.push_back({32'h41400000, 1'b0, 1'b0});
    base = issues;
    start_run(1);
    bus.i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("bp ready held", 32'(bus.o_ready), 32'd1);
      check("bp no issue", 32'(bus.o_mac_valid), 32'd0);
      @(negedge clk);
    end
    issue_pair("bp", 32'h40400000, 32'h40800000, 32'h0, hs);
    bus.i_valid = 1'b0;
    wait_done("bp", hs, 32'h41400000, 1'b0, 1'b0, 1'b0, 7);
    check("bp issue count", issues - base, 32'd1);

    // Reset in WAIT, the MAC result that follows must be ignored
    mac_q.push_back({32'h40000000, 1'b0, 1'b0});
    mac_q.push_back({32'h40c00000, 1'b0, 1'b0});
    start_run(2);
    issue_pair("rst", 32'h3f800000, 32'h40000000, 32'h0, hs);
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst busy", 32'(bus.o_busy), 32'd0);
    check("rst ready", 32'(bus.o_ready), 32'd0);
    check("rst mac_valid", 32'(bus.o_mac_valid), 32'd0);
    check("rst mac_a", bus.o_mac_a, 32'h0);
    check("rst mac_b", bus.o_mac_b, 32'h0);
    check("rst res", bus.o_res, 32'h0);
    check("rst res_valid", 32'(bus.o_res_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post-rst idle", 32'(bus.o_busy), 32'd0);
      check("post-rst no res", 32'(bus.o_res_valid), 32'd0);
    end
    check("post-rst res", bus.o_res, 32'h0);
    mac_q.delete();

`ifdef FLP_DOTSEQ_WDOG_EN
    // MAC never answers: abort MAC_LAT+2 cycles after entering WAIT
    mac_en = 1'b0;
    start_run(1);
    issue_pair("wd", 32'h3f800000, 32'h40000000, 32'h0, hs);
    bus.i_valid = 1'b0;
    wait_done("wd", hs, 32'h0, 1'b0, 1'b0, 1'b1, MAC_LAT + 3);
    check("wd err held", 32'(bus.o_res_err), 32'd1);
    start_run(0);
    check("wd err cleared", 32'(bus.o_res_err), 32'd0);
    check("wd zl res_valid", 32'(bus.o_res_valid), 32'd1);
    repeat (8) @(negedge clk);
    mac_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
